// File: rtl/conway_grid_serial.sv
// Serially loaded/unloaded Game-of-Life engine (rule B3/S23) over a WIDTH x HEIGHT grid.
// Optional still-life detection is enabled by defining CONWAY_STABLE_DETECT_EN.
module conway_grid_serial #(
    parameter int WIDTH   = 8,
    parameter int HEIGHT  = 8,
    parameter int RUN_DIV = 1,
    parameter int GEN_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data_in,
    input  logic [1:0]       mode,
    input  logic             wrap,
    output logic             data_out,
    output logic             done,
    output logic [GEN_W-1:0] gen_count,
    output logic             all_dead,
    output logic             din_led,
    output logic             clk_led,
    output logic             dout_led,
    output logic [1:0]       mode_leds,
    output logic             stable
);

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'b00,
        MODE_LOAD   = 2'b01,
        MODE_RUN    = 2'b10,
        MODE_UNLOAD = 2'b11
    } mode_e;

    localparam int N     = WIDTH * HEIGHT;
    localparam int CNT_W = $clog2(N + 1);
    localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [CNT_W-1:0] N_CNT    = CNT_W'(N);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    logic [N-1:0]     grid;
    logic [N-1:0]     next_grid;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] cnt;
    logic [DIV_W-1:0] div;

    // A mode change restarts the shift counter and the generation divider in the same cycle.
    logic             entry;
    logic [CNT_W-1:0] cnt_eff;
    logic [DIV_W-1:0] div_eff;
    logic             shifting;
    logic             shift_en;
    logic             tick;
    logic             gen_inc;
    logic             shift_bit;

    assign entry     = (mode != mode_q);
    assign cnt_eff   = entry ? '0 : cnt;
    assign div_eff   = entry ? '0 : div;
    assign shifting  = (mode == MODE_LOAD) || (mode == MODE_UNLOAD);
    assign shift_en  = shifting && (cnt_eff < N_CNT);
    assign tick      = (mode == MODE_RUN) && (div_eff == DIV_LAST);
    assign shift_bit = (mode == MODE_LOAD) ? data_in : grid[0];

    assign done      = shifting && (cnt_eff == N_CNT);
    assign data_out  = grid[0];
    assign dout_led  = grid[0];
    assign din_led   = data_in;
    assign mode_leds = mode_q;
    assign all_dead  = ~|grid;

    // Neighbour indices are resolved at elaboration; only the wrap mask is decided at run time.
    for (genvar r = 0; r < HEIGHT; r++) begin : g_row
        for (genvar c = 0; c < WIDTH; c++) begin : g_col
            localparam int RU = (r + HEIGHT - 1) % HEIGHT;
            localparam int RD = (r + 1) % HEIGHT;
            localparam int CL = (c + WIDTH - 1) % WIDTH;
            localparam int CR = (c + 1) % WIDTH;
            localparam logic TOP = (r == 0);
            localparam logic BOT = (r == HEIGHT - 1);
            localparam logic LFT = (c == 0);
            localparam logic RGT = (c == WIDTH - 1);
            localparam logic [7:0] INNER = {!(TOP || LFT), !TOP, !(TOP || RGT), !LFT,
                                            !RGT, !(BOT || LFT), !BOT, !(BOT || RGT)};

            logic [7:0] nb;
            logic [7:0] live;
            logic [3:0] n;

            assign nb = {grid[RU*WIDTH+CL], grid[RU*WIDTH+c], grid[RU*WIDTH+CR], grid[r*WIDTH+CL],
                         grid[r*WIDTH+CR], grid[RD*WIDTH+CL], grid[RD*WIDTH+c], grid[RD*WIDTH+CR]};
            assign live = nb & (INNER | {8{wrap}});
            assign n = 4'(live[7]) + 4'(live[6]) + 4'(live[5]) + 4'(live[4])
                     + 4'(live[3]) + 4'(live[2]) + 4'(live[1]) + 4'(live[0]);
            assign next_grid[r*WIDTH+c] = (n == 4'd3) || (grid[r*WIDTH+c] && (n == 4'd2));
        end
    end

`ifdef CONWAY_STABLE_DETECT_EN
    logic stable_q;
    logic grid_same;

    assign grid_same = (next_grid == grid);
    assign gen_inc   = tick && !grid_same;
    assign stable    = stable_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_q <= 1'b0;
        end else if (entry && (mode == MODE_LOAD)) begin
            stable_q <= 1'b0;
        end else if (tick) begin
            stable_q <= grid_same;
        end
    end
`else
    assign gen_inc = tick;
    assign stable  = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the grid is a plain flop array, not a RAM, so it can and must clear on reset.
            grid    <= '0;
            mode_q  <= MODE_IDLE;
            cnt     <= '0;
            div     <= '0;
            clk_led <= 1'b0;
        end else begin
            mode_q <= mode;
            cnt    <= cnt_eff;
            div    <= div_eff;
            if (shift_en) begin
                grid    <= {shift_bit, grid[N-1:1]};
                cnt     <= cnt_eff + CNT_W'(1);
                clk_led <= ~clk_led;
            end else if (mode == MODE_RUN) begin
                if (tick) begin
                    grid    <= next_grid;
                    div     <= '0;
                    clk_led <= ~clk_led;
                end else begin
                    div <= div_eff + DIV_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gen_count <= '0;
        end else if (entry && (mode == MODE_LOAD)) begin
            gen_count <= '0;
        end else if (gen_inc) begin
            gen_count <= gen_count + GEN_W'(1);
        end
    end

endmodule

// File: tb/tb_conway_grid_serial.sv
// Randomised scoreboard bench for conway_grid_serial against a cell-array reference model.
`timescale 1ns/1ps
module tb_conway_grid_serial;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int RD = 3;
    localparam int GW = 8;
    localparam int N  = W * H;

    logic          clk = 1'b0;
    logic          reset;
    logic          data_in;
    logic [1:0]    mode;
    logic          wrap;
    logic          data_out, done, all_dead, din_led, clk_led, dout_led, stable;
    logic [GW-1:0] gen_count;
    logic [1:0]    mode_leds;

    conway_grid_serial #(.WIDTH(W), .HEIGHT(H), .RUN_DIV(RD), .GEN_W(GW)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .mode(mode), .wrap(wrap),
        .data_out(data_out), .done(done), .gen_count(gen_count), .all_dead(all_dead),
        .din_led(din_led), .clk_led(clk_led), .dout_led(dout_led), .mode_leds(mode_leds),
        .stable(stable)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit          data_out;
        bit          done;
        bit          all_dead;
        bit          din_led;
        bit          clk_led;
        bit          dout_led;
        bit          stable;
        bit [1:0]    mode_leds;
        bit [GW-1:0] gen_count;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state
    bit       m_grid[N];
    bit       m_next[N];
    bit       pat[N];
    int       m_cnt, m_div, m_gen;
    bit       m_led, m_stable;
    bit [1:0] m_mode_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        foreach (m_grid[i]) m_grid[i] = 1'b0;
        m_cnt = 0; m_div = 0; m_gen = 0;
        m_led = 1'b0; m_stable = 1'b0; m_mode_q = 2'b00;
    endfunction

    function automatic void model_life(input bit w);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                int n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        int rr = r + dr;
                        int cc = c + dc;
                        if (dr == 0 && dc == 0) continue;
                        if (w) n += m_grid[((rr + H) % H) * W + ((cc + W) % W)];
                        else if (rr >= 0 && rr < H && cc >= 0 && cc < W) n += m_grid[rr * W + cc];
                    end
                end
                m_next[r * W + c] = (n == 3) || (m_grid[r * W + c] && n == 2);
            end
        end
    endfunction

    // One clock cycle: drive inputs, predict this cycle's outputs, then advance the model.
    task automatic step(input bit rst, input bit [1:0] md, input bit din, input bit w);
        exp_t e;
        bit   entry, any_live, changed, b0;
        int   cnt_e, div_e;
        @(posedge clk);
        #2;
        reset = rst; mode = md; data_in = din; wrap = w;
        if (rst) model_reset();
        entry = (md != m_mode_q);
        cnt_e = entry ? 0 : m_cnt;
        div_e = entry ? 0 : m_div;
        any_live = 1'b0;
        foreach (m_grid[i]) any_live |= m_grid[i];
        e.data_out  = m_grid[0];
        e.dout_led  = m_grid[0];
        e.done      = (md == 2'b01 || md == 2'b11) && cnt_e == N;
        e.all_dead  = !any_live;
        e.din_led   = din;
        e.clk_led   = m_led;
        e.stable    = m_stable;
        e.mode_leds = m_mode_q;
        e.gen_count = GW'(m_gen);
        sb_q.push_back(e);
        if (rst) return;
        m_mode_q = md;
        m_cnt = cnt_e;
        m_div = div_e;
        if (entry && md == 2'b01) begin m_gen = 0; m_stable = 1'b0; end
        if (md == 2'b01 || md == 2'b11) begin
            if (m_cnt < N) begin
                b0 = m_grid[0];
                for (int i = 0; i < N - 1; i++) m_grid[i] = m_grid[i + 1];
                m_grid[N - 1] = (md == 2'b01) ? din : b0;
                m_cnt++;
                m_led = !m_led;
            end
        end else if (md == 2'b10) begin
            if (m_div == RD - 1) begin
                m_div = 0;
                m_led = !m_led;
                model_life(w);
                changed = 1'b0;
                foreach (m_grid[i]) changed |= (m_grid[i] != m_next[i]);
`ifdef CONWAY_STABLE_DETECT_EN
                m_stable = !changed;
                if (changed) m_gen = (m_gen + 1) % (1 << GW);
`else
                m_gen = (m_gen + 1) % (1 << GW);
`endif
                m_grid = m_next;
            end else begin
                m_div++;
            end
        end
    endtask

    task automatic set_pat(input int idx[$]);
        foreach (pat[i]) pat[i] = 1'b0;
        foreach (idx[k]) pat[idx[k]] = 1'b1;
    endtask

    task automatic load_pat();
        for (int i = 0; i < N; i++) step(0, 2'b01, pat[i], 0);
        step(0, 2'b01, 1'b1, 0);
        step(0, 2'b01, 1'b0, 0);
    endtask

    task automatic unload_cycles(input int k);
        for (int i = 0; i < k; i++) step(0, 2'b11, 1'($urandom_range(1)), 0);
    endtask

    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) step(0, 2'b00, 1'($urandom_range(1)), 1'($urandom_range(1)));
    endtask

    task automatic run_cycles(input int k, input bit w);
        for (int i = 0; i < k; i++) step(0, 2'b10, 1'($urandom_range(1)), w);
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("data_out",  32'(data_out),  32'(e.data_out));
                check("done",      32'(done),      32'(e.done));
                check("all_dead",  32'(all_dead),  32'(e.all_dead));
                check("din_led",   32'(din_led),   32'(e.din_led));
                check("clk_led",   32'(clk_led),   32'(e.clk_led));
                check("dout_led",  32'(dout_led),  32'(e.dout_led));
                check("stable",    32'(stable),    32'(e.stable));
                check("mode_leds", 32'(mode_leds), 32'(e.mode_leds));
                check("gen_count", 32'(gen_count), 32'(e.gen_count));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; mode = 2'b00; data_in = 1'b0; wrap = 1'b0;
        model_reset();
        repeat (3) step(1, 2'b00, 0, 0);
        idle_cycles(2);

        // Horizontal blinker: load, unload twice to show the grid is restored.
        set_pat('{26, 27, 28});
        load_pat();
        unload_cycles(N + 2);
        unload_cycles(N + 2);

        // Reset asserted mid-unload, then idle hold.
        load_pat();
        unload_cycles(10);
        step(1, 2'b11, 0, 0);
        idle_cycles(5);

        // Blinker oscillation with dead border, two generations.
        load_pat();
        run_cycles(2 * RD, 0);
        unload_cycles(N + 1);

        // Corner pattern under wrap and under dead border.
        set_pat('{0, 1, 7});
        load_pat();
        run_cycles(RD, 1);
        unload_cycles(N + 1);
        load_pat();
        run_cycles(RD, 0);
        unload_cycles(N + 1);

        // Divider restart: leave RUN mid-count and re-enter.
        set_pat('{26, 27, 28});
        load_pat();
        run_cycles(RD + 2, 0);
        idle_cycles(1);
        run_cycles(RD + 1, 0);
        unload_cycles(N + 1);

        // Still life block.
        set_pat('{9, 10, 17, 18});
        load_pat();
        run_cycles(2 * RD, 0);
        run_cycles(RD, 1);
        unload_cycles(N + 1);

        // Random grids and random mode segments, with occasional resets.
        for (int it = 0; it < 40; it++) begin
            int dens = $urandom_range(1, 3);
            foreach (pat[i]) pat[i] = ($urandom_range(3) < dens);
            load_pat();
            for (int s = 0; s < 6; s++) begin
                bit [1:0] md  = 2'($urandom_range(3));
                int       len = $urandom_range(1, N + 5);
                for (int k = 0; k < len; k++) begin
                    bit rst = ($urandom_range(199) == 0);
                    step(rst, md, 1'($urandom_range(1)), 1'($urandom_range(1)));
                end
            end
            unload_cycles(N + 1);
        end

        idle_cycles(2);
        @(negedge clk);
        #1;
        check("scoreboard_drain", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
